// File: rtl/screen_pkg.sv
// Shared types and constants for the screen/UART frame path.
package screen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int DATA_W_DEFAULT = 10;
  localparam int BAUD_DIV       = 5208;

  // Counter width able to hold 0..maxVal, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first requester above lastGrant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   lastGrant,
  output logic [NUM_REQ-1:0] grantOh,
  output logic [IDX_W-1:0]   grantIdx
);

  logic found;
  int   cand;

  // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
  always_comb begin
    grantOh  = '0;
    grantIdx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(lastGrant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && reqVec[cand]) begin
        grantOh[cand] = 1'b1;
        grantIdx      = IDX_W'(cand);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_arbiter.sv
// Arbitrates several frame requesters onto one UART transmitter,
// enforcing an idle gap between frames and an acceptance timeout.
module screen_arbiter
  import screen_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int GAP_CYCLES  = BAUD_DIV,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_ovalid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_oready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        tx_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = cntWidth(GAP_CYCLES);
  localparam int TO_W  = cntWidth(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  state_t             state, nextState;
  logic [DATA_W-1:0]  dataBuf;
  logic [IDX_W-1:0]   lastGrant;
  logic [GAP_W-1:0]   gapCnt;
  logic [TO_W-1:0]    toCnt;
  logic [NUM_REQ-1:0] winOh;
  logic [IDX_W-1:0]   winIdx;
  logic               transfer;
  logic               timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .reqVec    (req_valid),
    .lastGrant (lastGrant),
    .grantOh   (winOh),
    .grantIdx  (winIdx)
  );

  assign transfer = (state == IDLE) && tx_oready && (|winOh);
  assign timeout  = (state == SEND) && tx_oready && (toCnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (transfer) nextState = SEND;
      SEND: begin
        if (!tx_oready)   nextState = WAIT_DONE;
        else if (timeout) nextState = IDLE;
      end
      WAIT_DONE: if (tx_oready) nextState = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gapCnt == '0) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = transfer ? winOh : '0;
    tx_ovalid = (state == SEND);
    busy      = (state != IDLE);
    tx_data   = dataBuf;
  end

  // A frame lost to reset is simply dropped; the buffer is cleared with the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataBuf   <= '0;
      lastGrant <= IDX_W'(NUM_REQ - 1);
      grant_id  <= '0;
      gapCnt    <= '0;
      toCnt     <= '0;
      tx_err    <= 1'b0;
    end else begin
      tx_err <= timeout;
      if (transfer) begin
        dataBuf   <= req_data[int'(winIdx)*DATA_W +: DATA_W];
        lastGrant <= winIdx;
        grant_id  <= winIdx;
      end
      if (state != SEND)                            toCnt <= '0;
      else if (tx_oready && nextState == SEND)      toCnt <= toCnt + 1'b1;
      if (state == WAIT_DONE && tx_oready)          gapCnt <= GAP_LOAD;
      else if (state == GAP && gapCnt != '0)        gapCnt <= gapCnt - 1'b1;
    end
  end

endmodule

// File: doc/screen_arbiter.md
SCREEN_ARBITER -- requirements
Module: screen_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of frame requesters (2..4).
REQ-002 SHALL have parameter DATA_W, default 10, UART frame width in bits.
REQ-003 SHALL have parameter GAP_CYCLES, default 5208, minimum idle clocks between frames (one bit time at 50 MHz / 9600 baud).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 16, maximum clocks to wait for transmitter acceptance.
REQ-005 SHALL have one clock and an asynchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a frame
- req_data  in  NUM_REQ*DATA_W  packed frames; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot; frame i accepted this cycle
- tx_ovalid  out  1  to transmitter ovalid
- tx_data  out  DATA_W  to transmitter inputScreen
- tx_oready  in  1  from transmitter oready
- grant_id  out  clog2(NUM_REQ)  index of the requester currently or last served
- busy  out  1  high whenever state is not IDLE
- tx_err  out  1  one-cycle pulse on acceptance timeout

Function
REQ-006 SHALL implement FSM states IDLE, SEND, WAIT_DONE and GAP.
REQ-007 SHALL drive req_ready[i] combinationally high only when: state is IDLE, tx_oready is 1, req_valid[i] is 1, and i is the round-robin winner; at most one bit is set.
REQ-008 SHALL select the round-robin winner as the first valid requester searching upward from last_grant+1, wrapping modulo NUM_REQ.
REQ-009 SHALL, on a transfer (valid and ready in IDLE), latch req_data slice i into data_buf, set last_grant and grant_id to i, and enter SEND on the next edge.
REQ-010 SHALL, in SEND, hold tx_ovalid=1 and tx_data=data_buf, and count the cycles spent in SEND.
REQ-011 SHALL, in SEND, enter WAIT_DONE and drop tx_ovalid on the first sampled tx_oready=0; tx_ovalid stays high for that one cycle after acceptance, which the transmitter ignores.
REQ-012 SHALL, in SEND, if ACK_TIMEOUT cycles elapse with tx_oready still 1: pulse tx_err for one cycle, drop the frame and return to IDLE.
REQ-013 SHALL, in WAIT_DONE, hold tx_ovalid=0 and, on tx_oready=1, load gap_cnt with GAP_CYCLES-1 and enter GAP; if GAP_CYCLES=0, enter IDLE directly.
REQ-014 SHALL, in GAP, decrement gap_cnt each clock and enter IDLE in the cycle after gap_cnt reaches 0.
REQ-015 SHALL give throughput of at most one frame per (tx frame time + GAP_CYCLES + 2) clocks; minimum latency from req_valid in IDLE to tx_ovalid is 1 clock.
REQ-016 SHALL drive tx_data=data_buf in all states; its value is don't-care outside SEND.
REQ-017 SHALL keep req_ready low for all requesters while not in IDLE; requesters hold valid and data stable until ready.
REQ-018 SHALL, if tx_oready=0 while in IDLE, grant nothing and wait.
REQ-019 SHALL size gap_cnt to clog2(GAP_CYCLES+1) and the timeout counter to clog2(ACK_TIMEOUT+1); neither counter may wrap.

Reset
REQ-020 SHALL, while reset=1, force: state IDLE, tx_ovalid 0, req_ready 0, busy 0, tx_err 0, data_buf 0, counters 0, last_grant NUM_REQ-1 (requester 0 wins first), grant_id 0.
REQ-021 SHALL, on reset asserted mid-frame, drop tx_ovalid asynchronously and discard the pending frame; it is not retried.

Structure
REQ-022 SHALL take the state enum, DATA_W default and the BAUD_DIV=5208 constant from shared package screen_pkg.
REQ-023 SHALL place winner selection in sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index).

Verification
REQ-024 Single request: req_valid[0]=1, data 10'h2A5, tx idle -> req_ready[0] pulses 1 cycle; tx_ovalid high next cycle with tx_data=10'h2A5.
REQ-025 Contention: both requesters valid continuously -> grants alternate 0,1,0,1 across four frames; each gap is >= GAP_CYCLES clocks after tx_oready rises.
REQ-026 Timeout: tx_oready tied 1 -> tx_err pulses exactly once, 16 cycles after SEND entry; FSM returns to IDLE.
REQ-027 Mid-frame reset: assert reset in WAIT_DONE -> tx_ovalid 0 and busy 0 immediately; after release, requester 0 wins first.
REQ-028 Back-pressure: tx_oready=0 in IDLE with req_valid[1]=1 -> no req_ready until tx_oready=1, then req_ready[1] in that same cycle.
REQ-029 End to end: connect the real transmitter with GAP_CYCLES=0 -> serial line shows all 10 bits of each frame, and no frame starts before the previous one completes.
